module_acc_array: RTL and testbench
===================================

Name: module_acc_array

Overview:
- Parametrised multi-channel partial-sum accumulator for the conv datapath; generalises the fixed 8-channel, 18-bit accumulator bank.
- Per beat, each of CH lanes adds an incoming partial sum to the value stored at a shared feature-map address and writes the total back.
- New features: saturating add, back-to-back same-address hazard forwarding, explicit final-pass readout stream, sticky saturation flag.
- Sits between the MAC array output and the bias/activation/requant stage.

Parameters:
- CH, 8, number of output-channel lanes.
- DW, 18, signed data width per lane.
- DEPTH, 114*114, words per lane buffer.
- ADDR_BIT, 14, address width; DEPTH <= 2**ADDR_BIT.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, beat present this cycle; no backpressure, accepted every cycle.
- in_addr, in, ADDR_BIT, accumulation address; must be < DEPTH.
- in_first, in, 1, first pass: stored value treated as 0 (was prev_data_zero).
- in_zero, in, 1, incoming data treated as 0 (was curr_data_zero).
- in_last, in, 1, final pass: result also emitted on out_*.
- in_data, in, CH*DW, lane i at [i*DW +: DW], signed.
- sat_clr, in, 1, clears sat_sticky.
- out_valid, out, 1, final result beat.
- out_addr, out, ADDR_BIT, address of emitted result.
- out_data, out, CH*DW, final accumulated values.
- sat_sticky, out, CH, per-lane flag: saturation occurred since reset/clear.

Behaviour:
- Pipeline, no stalls. Beat accepted at cycle t:
  - t: RAM read issued at in_addr; ctrl and data registered into stage P1.
  - t+1: RAM dout valid. prev = 0 if first, else forwarded or dout. curr = 0 if zero, else data. sum = sat(prev + curr), registered into P2.
  - t+2: P2 writes sum to in_addr. If last, out_valid=1 with out_addr and out_data = sum. Input-to-output latency is 2 cycles.
- RAM: simple dual-port, read-first, 1-cycle read latency, per-lane DW wide.
- Hazard forwarding, evaluated at P1 compute:
  - If P2 valid and P2.addr == P1.addr, prev = P2.sum (write in progress this cycle).
  - Else if P3 valid and P3.addr == P1.addr, prev = P3.sum (write landed the cycle the read was issued; read-first returned stale data).
  - Else prev = RAM dout.
  - P2 has priority over P3. P3 is a one-cycle copy of P2 (addr, sum, valid). Forwarding is ignored when in_first.
- Arithmetic:
  - Add in DW+1 bits, clamp to [-(2**(DW-1)), 2**(DW-1)-1].
  - Clamp sets sat_sticky[i] the cycle after P2 loads.
  - sat_clr and a new saturation in the same cycle: set wins.
- in_first and in_zero both set: sum = 0; it is still written, and emitted if last.
- in_last beats are still written back, so RAM holds the final value.
- Idle cycles (in_valid=0): no write, out_valid=0; pipeline valids shift in 0.
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_addr=0, out_data=0, sat_sticky=0, all stage valids=0.
  - In-flight beats are dropped and no write occurs while rst_n=0.
  - RAM contents are not reset; the next layer starts with in_first.
- Out-of-range in_addr is undefined use; no checking in RTL (assertion in bench).

Decomposition:
- Package acc_pkg:
  - default DW/CH constants.
  - function sat_add(a, b) returning {sat_flag, DW-bit sum}.
  - lane slice helper.
- Sub-module acc_lane_ram: SDP, read-first, 1-cycle BRAM, params DW/DEPTH/ADDR_BIT. Instantiated CH times via generate.
- Pipeline control and forwarding muxes stay in the top, shared by all lanes; only data paths are per-lane.

Test Plan:
- Basic: addr 5, first+data 10, then data 7 +last, with gaps of 3 idle cycles -> out_valid 2 cycles after second beat, out_addr=5, all lanes 17.
- Back-to-back forwarding: addr 9 on consecutive cycles: first 1, then 2, then 3 +last -> out 6 (P2 path).
- Gap-of-one forwarding: addr 9 on cycles t and t+2, with a different addr at t+1 -> P3 path, correct sum.
- Saturation: DW=18, first 131000, then 100 +last -> out 131071; sat_sticky lane set. sat_clr -> 0. Negative mirror clamps to -131072.
- Zero flags:
  - in_zero on a middle pass leaves the value unchanged.
  - in_first+in_zero+last -> out 0.
  - in_first on an address holding 50 -> result ignores 50.
- Reset mid-stream: assert rst_n=0 while 2 beats are in flight -> no out_valid, outputs 0, no RAM write; after release, first-pass accumulation is correct.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel partial-sum accumulator.
package acc_pkg;

    localparam int DEF_CH = 8;
    localparam int DEF_DW = 18;
    localparam int MAX_DW = 32;

    // Low bit of lane `lane` inside a packed CH*dw bus.
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

    // Signed add clamped to dw bits; returns {sat_flag, sum}. Operands arrive sign-extended to MAX_DW.
    function automatic logic [MAX_DW:0] sat_add(input logic signed [MAX_DW-1:0] a,
                                                input logic signed [MAX_DW-1:0] b,
                                                input int dw);
        logic signed [MAX_DW:0] s;
        logic signed [MAX_DW:0] hi;
        logic signed [MAX_DW:0] lo;
        s  = (MAX_DW+1)'(a) + (MAX_DW+1)'(b);
        hi = ((MAX_DW+1)'(1) <<< (dw - 1)) - (MAX_DW+1)'(1);
        lo = -hi - (MAX_DW+1)'(1);
        if (s > hi)
            return {1'b1, hi[MAX_DW-1:0]};
        else if (s < lo)
            return {1'b1, lo[MAX_DW-1:0]};
        else
            return {1'b0, s[MAX_DW-1:0]};
    endfunction

endpackage

// File: rtl/acc_lane_ram.sv
// One lane of the accumulation buffer: simple dual-port, read-first, 1-cycle read latency.
module acc_lane_ram #(
    parameter int DW       = 18,
    parameter int DEPTH    = 114*114,
    parameter int ADDR_BIT = 14
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_BIT-1:0] wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic [ADDR_BIT-1:0] rd_addr,
    output logic [DW-1:0]       rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: no reset on the array or its read register, so this maps onto block RAM; each layer starts with in_first instead.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/module_acc_array.sv
// CH-lane saturating partial-sum accumulator with same-address hazard forwarding and a final-pass readout stream.
module module_acc_array
    import acc_pkg::*;
#(
    parameter int CH       = DEF_CH,
    parameter int DW       = DEF_DW,
    parameter int DEPTH    = 114*114,
    parameter int ADDR_BIT = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [ADDR_BIT-1:0] in_addr,
    input  logic                in_first,
    input  logic                in_zero,
    input  logic                in_last,
    input  logic [CH*DW-1:0]    in_data,
    input  logic                sat_clr,
    output logic                out_valid,
    output logic [ADDR_BIT-1:0] out_addr,
    output logic [CH*DW-1:0]    out_data,
    output logic [CH-1:0]       sat_sticky
);

    logic                p1_valid, p1_first, p1_zero, p1_last;
    logic [ADDR_BIT-1:0] p1_addr;
    logic [CH*DW-1:0]    p1_data;

    logic                p2_valid, p2_last;
    logic [ADDR_BIT-1:0] p2_addr;
    logic [CH*DW-1:0]    p2_sum;
    logic [CH-1:0]       p2_sat;

    logic                p3_valid;
    logic [ADDR_BIT-1:0] p3_addr;
    logic [CH*DW-1:0]    p3_sum;

    logic [CH*DW-1:0]    sum_next;
    logic [CH-1:0]       sat_next;
    logic                fwd_p2, fwd_p3;

    // P2 is writing this cycle; P3 wrote on the edge the P1 read was issued, so read-first returned stale data.
    assign fwd_p2 = p2_valid && (p2_addr == p1_addr);
    assign fwd_p3 = p3_valid && (p3_addr == p1_addr);

    for (genvar i = 0; i < CH; i++) begin : g_lane
        logic signed [DW-1:0] dout;
        logic signed [DW-1:0] prev;
        logic signed [DW-1:0] curr;
        logic [MAX_DW:0]      res;
        logic [MAX_DW-DW-1:0] unused_ext;

        acc_lane_ram #(
            .DW       (DW),
            .DEPTH    (DEPTH),
            .ADDR_BIT (ADDR_BIT)
        ) u_ram (
            .clk     (clk),
            .wr_en   (p2_valid),
            .wr_addr (p2_addr),
            .wr_data (p2_sum[lane_lo(i, DW) +: DW]),
            .rd_addr (in_addr),
            .rd_data (dout)
        );

        // NOTE: every branch assigns prev and curr, so this stays purely combinational with no latch.
        always_comb begin
            if (p1_first)
                prev = '0;
            else if (fwd_p2)
                prev = p2_sum[lane_lo(i, DW) +: DW];
            else if (fwd_p3)
                prev = p3_sum[lane_lo(i, DW) +: DW];
            else
                prev = dout;
            curr = p1_zero ? '0 : p1_data[lane_lo(i, DW) +: DW];
            res  = sat_add(MAX_DW'(prev), MAX_DW'(curr), DW);
        end

        // Bits above DW are only sign extension of the clamped result.
        assign unused_ext                  = res[MAX_DW-1:DW];
        assign sum_next[lane_lo(i, DW) +: DW] = res[DW-1:0];
        assign sat_next[i]                 = res[MAX_DW];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid   <= 1'b0;
            p1_first   <= 1'b0;
            p1_zero    <= 1'b0;
            p1_last    <= 1'b0;
            p1_addr    <= '0;
            p1_data    <= '0;
            p2_valid   <= 1'b0;
            p2_last    <= 1'b0;
            p2_addr    <= '0;
            p2_sum     <= '0;
            p2_sat     <= '0;
            p3_valid   <= 1'b0;
            p3_addr    <= '0;
            p3_sum     <= '0;
            sat_sticky <= '0;
        end else begin
            p1_valid <= in_valid;
            p1_first <= in_first;
            p1_zero  <= in_zero;
            p1_last  <= in_last;
            p1_addr  <= in_addr;
            p1_data  <= in_data;

            p2_valid <= p1_valid;
            p2_last  <= p1_valid & p1_last;
            p2_addr  <= p1_addr;
            p2_sum   <= sum_next;
            p2_sat   <= p1_valid ? sat_next : '0;

            p3_valid <= p2_valid;
            p3_addr  <= p2_addr;
            p3_sum   <= p2_sum;

            // A new saturation wins over a simultaneous clear.
            sat_sticky <= (sat_sticky & ~{CH{sat_clr}}) | (p2_valid ? p2_sat : '0);
        end
    end

    assign out_valid = p2_valid & p2_last;
    assign out_addr  = p2_addr;
    assign out_data  = p2_sum;

endmodule

// File: tb/tb_module_acc_array.sv
// Randomised and directed bench for module_acc_array against an in-order accumulation model.
module tb_module_acc_array;

    localparam int CH       = 8;
    localparam int DW       = 18;
    localparam int DEPTH    = 114*114;
    localparam int ADDR_BIT = 14;
    localparam int W        = CH*DW;
    localparam int MAXV     = (1 << (DW-1)) - 1;
    localparam int MINV     = -(1 << (DW-1));

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [ADDR_BIT-1:0] in_addr = '0;
    logic                in_first = 1'b0;
    logic                in_zero = 1'b0;
    logic                in_last = 1'b0;
    logic [W-1:0]        in_data = '0;
    logic                sat_clr = 1'b0;
    logic                out_valid;
    logic [ADDR_BIT-1:0] out_addr;
    logic [W-1:0]        out_data;
    logic [CH-1:0]       sat_sticky;

    always #5 clk = ~clk;

    module_acc_array #(
        .CH       (CH),
        .DW       (DW),
        .DEPTH    (DEPTH),
        .ADDR_BIT (ADDR_BIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_addr    (in_addr),
        .in_first   (in_first),
        .in_zero    (in_zero),
        .in_last    (in_last),
        .in_data    (in_data),
        .sat_clr    (sat_clr),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .sat_sticky (sat_sticky)
    );

    // One accepted beat as the model sees it, plus the values it overwrote so a reset can undo it.
    typedef struct {
        bit            valid;
        bit            last;
        int            addr;
        logic [W-1:0]  data;
        logic [CH-1:0] sat;
        bit            had_old;
        int            old_val[CH];
    } pend_t;

    int            model_mem [int];
    pend_t         pend[$];
    logic [CH-1:0] exp_sticky = '0;
    int            drv[CH];
    int            n_checks = 0;
    int            n_pass = 0;

    always @(posedge clk)
        if (rst_n && in_valid)
            assert (in_addr < ADDR_BIT'(DEPTH)) else $error("in_addr %0d beyond buffer depth", in_addr);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic pend_t empty_pend();
        pend_t e;
        e.valid   = 1'b0;
        e.last    = 1'b0;
        e.addr    = 0;
        e.data    = '0;
        e.sat     = '0;
        e.had_old = 1'b0;
        for (int i = 0; i < CH; i++) e.old_val[i] = 0;
        return e;
    endfunction

    // Beats are applied strictly in order, so later beats see earlier totals without any notion of pipeline timing.
    function automatic pend_t model_beat(input int addr, input bit first, input bit zero, input bit last);
        pend_t e;
        e         = empty_pend();
        e.valid   = 1'b1;
        e.last    = last;
        e.addr    = addr;
        e.had_old = model_mem.exists(addr*CH);
        for (int i = 0; i < CH; i++) begin
            int key;
            int prev;
            int curr;
            int s;
            key          = addr*CH + i;
            e.old_val[i] = e.had_old ? model_mem[key] : 0;
            prev         = (first || !e.had_old) ? 0 : model_mem[key];
            curr         = zero ? 0 : drv[i];
            s            = prev + curr;
            if (s > MAXV) begin
                s = MAXV;
                e.sat[i] = 1'b1;
            end else if (s < MINV) begin
                s = MINV;
                e.sat[i] = 1'b1;
            end
            model_mem[key] = s;
            e.data[i*DW +: DW] = DW'(s);
        end
        return e;
    endfunction

    task automatic check_outputs();
        bit ev;
        ev = pend[0].valid && pend[0].last;
        check("out_valid", W'(out_valid), W'(ev));
        if (ev) begin
            check("out_addr", W'(out_addr), W'(ADDR_BIT'(pend[0].addr)));
            check("out_data", out_data, pend[0].data);
        end
        check("sat_sticky", W'(sat_sticky), W'(exp_sticky));
    endtask

    // Drives one cycle: inputs applied just after the rising edge, outputs checked on the falling edge.
    task automatic drive(input bit v, input int addr, input bit first, input bit zero,
                         input bit last, input bit clr);
        pend_t e;
        in_valid = v;
        in_addr  = ADDR_BIT'(addr);
        in_first = first;
        in_zero  = zero;
        in_last  = last;
        sat_clr  = clr;
        for (int i = 0; i < CH; i++) in_data[i*DW +: DW] = DW'(drv[i]);
        @(negedge clk);
        check_outputs();
        e = v ? model_beat(addr, first, zero, last) : empty_pend();
        @(posedge clk);
        // Sticky picks up a beat's saturation two edges after acceptance.
        exp_sticky = (exp_sticky & ~{CH{clr}}) | (pend[0].valid ? pend[0].sat : '0);
        void'(pend.pop_front());
        pend.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill(input int x);
        for (int i = 0; i < CH; i++) drv[i] = x;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 3) == 0)
                drv[i] = int'($urandom_range(0, 2*MAXV + 1)) + MINV;
            else
                drv[i] = int'($urandom_range(0, 2000)) - 1000;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, W'(out_valid), W'(1'b0));
        check({tag, "_addr"}, W'(out_addr), W'(ADDR_BIT'(0)));
        check({tag, "_data"}, out_data, W'(0));
        check({tag, "_sticky"}, W'(sat_sticky), W'(CH'(0)));
    endtask

    initial begin
        fill(0);
        pend.push_back(empty_pend());
        pend.push_back(empty_pend());
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic two-pass accumulation with idle gaps: 10 + 7 = 17.
        fill(10); drive(1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        fill(7);  drive(1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Back-to-back same address: 1 + 2 + 3 = 6.
        fill(1); drive(1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(2); drive(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        fill(3); drive(1'b1, 9, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Same address two cycles apart with another address between: 4 + 5 = 9.
        fill(4); drive(1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(1); drive(1'b1, 11, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(5); drive(1'b1, 9, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Positive clamp on lane 3 only, then clear.
        fill(10);  drv[3] = 131000; drive(1'b1, 30, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(10);  drv[3] = 100;    drive(1'b1, 30, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Negative clamp on lane 5.
        fill(-5); drv[5] = -131000; drive(1'b1, 31, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(-5); drv[5] = -100;    drive(1'b1, 31, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Clear held across the cycle a new saturation lands: the new flag must survive.
        fill(0); drv[0] = MAXV; drive(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(0); drv[0] = 1;    drive(1'b1, 32, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Zero flags: middle zero pass, first+zero+last, first ignoring stored 50.
        fill(50); drive(1'b1, 40, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(99); drive(1'b1, 40, 1'b0, 1'b1, 1'b0, 1'b0);
        fill(1);  drive(1'b1, 40, 1'b0, 1'b0, 1'b1, 1'b0);
        fill(33); drive(1'b1, 40, 1'b1, 1'b1, 1'b1, 1'b0);
        fill(50); drive(1'b1, 41, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        fill(7);  drive(1'b1, 41, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Reset with two beats to address 20 in flight; neither may reach the buffer.
        fill(100); drive(1'b1, 20, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        fill(5);   drive(1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0);
        fill(6);   drive(1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        for (int k = 1; k >= 0; k--) begin
            if (pend[k].valid) begin
                for (int i = 0; i < CH; i++) begin
                    if (pend[k].had_old)
                        model_mem[pend[k].addr*CH + i] = pend[k].old_val[i];
                    else
                        model_mem.delete(pend[k].addr*CH + i);
                end
            end
        end
        pend.delete();
        pend.push_back(empty_pend());
        pend.push_back(empty_pend());
        exp_sticky = '0;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fill(1); drive(1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0);
        fill(3); drive(1'b1, 21, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(4); drive(1'b1, 21, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Random traffic over a small address set to exercise both forwarding paths.
        for (int a = 0; a < 8; a++) begin
            rand_lanes();
            drive(1'b1, a, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int n = 0; n < 400; n++) begin
            rand_lanes();
            drive($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
